// File: rtl/dmem_ctrl_pkg.sv
// Shared widths, RISC-V load/store width codes and FSM states for the dmem
// load/store controller.
package dmem_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_RD = 3'd1,
    S_WAIT_RD  = 3'd2,
    S_ISSUE_WR = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  // Misaligned halfword/word, reserved width codes, or unsigned-width stores.
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] f3,
                                      input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                 (we && f3[2]);
    misaligned = ((f3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((f3 == F3_W) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte/halfword lane logic: load extraction with sign/zero extension, and the
// merge of narrow store data into a previously read word.
module dmem_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_addr_lo,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load,
  output logic [XLEN-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every combinational output gets a value on every path (default
    // or default assignment first), otherwise synthesis infers a latch.
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'b0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'b0, w_half};
      F3_W:    o_load = i_word;
      default: o_load = '0;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_funct3[1:0])
      2'b00:   o_merged[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
      2'b01:   o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port (core / debug) round-robin arbiter and load/store sequencer in
// front of the word-addressed dmem; narrow stores become read-modify-write.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            core_req_valid,
  output logic            core_req_ready,
  input  logic            core_we,
  input  logic [2:0]      core_funct3,
  input  logic [XLEN-1:0] core_addr,
  input  logic [XLEN-1:0] core_wdata,
  output logic            core_resp_valid,
  output logic [XLEN-1:0] core_rdata,
  output logic            core_err,
  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  logic            dbg_we,
  input  logic [XLEN-1:0] dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_resp_valid,
  output logic [XLEN-1:0] dbg_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t          r_state;
  logic            r_last_dbg;
  logic            r_port_dbg;
  logic            r_we;
  logic [1:0]      r_addr_lo;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic            r_mem_we;
  logic            r_core_resp_valid;
  logic            r_core_err;
  logic [XLEN-1:0] r_core_rdata;
  logic            r_dbg_resp_valid;
  logic [XLEN-1:0] r_dbg_rdata;

  logic            w_grant_core;
  logic            w_grant_dbg;
  logic            w_accept;
  logic            w_we;
  logic            w_err;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_merged;

  // On contention the port that did not win last time gets the grant.
  assign w_grant_core = core_req_valid && (!dbg_req_valid || r_last_dbg);
  assign w_grant_dbg  = dbg_req_valid && (!core_req_valid || !r_last_dbg);

  assign core_req_ready = !rst && (r_state == S_IDLE) && w_grant_core;
  assign dbg_req_ready  = !rst && (r_state == S_IDLE) && w_grant_dbg;
  assign w_accept       = (r_state == S_IDLE) && (w_grant_core || w_grant_dbg);

  assign w_we    = w_grant_dbg ? dbg_we    : core_we;
  assign w_f3    = w_grant_dbg ? F3_W      : core_funct3;
  assign w_addr  = w_grant_dbg ? dbg_addr  : core_addr;
  assign w_wdata = w_grant_dbg ? dbg_wdata : core_wdata;
  assign w_err   = w_grant_core && access_err(core_we, core_funct3, core_addr[1:0]);

  dmem_lane u_lane (
    .i_word    (mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_f3),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  // NOTE: all state here is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_last_dbg        <= 1'b1;
      r_port_dbg        <= 1'b0;
      r_we              <= 1'b0;
      r_addr_lo         <= '0;
      r_f3              <= '0;
      r_wdata           <= '0;
      r_mem_addr        <= '0;
      r_mem_wdata       <= '0;
      r_mem_we          <= 1'b0;
      r_core_resp_valid <= 1'b0;
      r_core_err        <= 1'b0;
      r_core_rdata      <= '0;
      r_dbg_resp_valid  <= 1'b0;
      r_dbg_rdata       <= '0;
    end else begin
      // Response outputs are single-cycle pulses; data reads 0 outside them.
      r_core_resp_valid <= 1'b0;
      r_core_err        <= 1'b0;
      r_core_rdata      <= '0;
      r_dbg_resp_valid  <= 1'b0;
      r_dbg_rdata       <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_dbg <= w_grant_dbg;
            r_port_dbg <= w_grant_dbg;
            r_we       <= w_we;
            r_f3       <= w_f3;
            r_addr_lo  <= w_addr[1:0];
            r_wdata    <= w_wdata;
            if (w_err) begin
              r_state           <= S_RESP;
              r_core_resp_valid <= 1'b1;
              r_core_err        <= 1'b1;
            end else begin
              r_mem_addr <= {w_addr[XLEN-1:2], 2'b00};
              if (w_we && (w_f3 == F3_W)) begin
                r_state     <= S_ISSUE_WR;
                r_mem_we    <= 1'b1;
                r_mem_wdata <= w_wdata;
              end else begin
                r_state <= S_ISSUE_RD;
              end
            end
          end
        end
        S_ISSUE_RD: r_state <= S_WAIT_RD;
        S_WAIT_RD: begin
          if (r_we) begin
            r_state     <= S_ISSUE_WR;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_merged;
          end else begin
            r_state <= S_RESP;
            if (r_port_dbg) begin
              r_dbg_resp_valid <= 1'b1;
              r_dbg_rdata      <= w_load;
            end else begin
              r_core_resp_valid <= 1'b1;
              r_core_rdata      <= w_load;
            end
          end
        end
        S_ISSUE_WR: begin
          r_state  <= S_RESP;
          r_mem_we <= 1'b0;
          if (r_port_dbg) r_dbg_resp_valid  <= 1'b1;
          else            r_core_resp_valid <= 1'b1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_resp_valid = r_core_resp_valid;
  assign core_rdata      = r_core_rdata;
  assign core_err        = r_core_err;
  assign dbg_resp_valid  = r_dbg_resp_valid;
  assign dbg_rdata       = r_dbg_rdata;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign mem_we          = r_mem_we;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: behavioural dmem model, table-driven core
// accesses, plus hand-written arbitration, debug and mid-operation reset cases.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req_valid = 1'b0, core_req_ready, core_we = 1'b0;
  logic [2:0]  core_funct3 = 3'b0;
  logic [31:0] core_addr = '0, core_wdata = '0, core_rdata;
  logic        core_resp_valid, core_err;
  logic        dbg_req_valid = 1'b0, dbg_req_ready, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0, dbg_rdata;
  logic        dbg_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:63] = '{default: '0};
  logic        preload = 1'b1;
  int          we_cnt = 0, core_resp_cnt = 0, dbg_resp_cnt = 0;
  logic [31:0] last_wdata = '0;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_we(core_we), .core_funct3(core_funct3), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_resp_valid(core_resp_valid),
    .core_rdata(core_rdata), .core_err(core_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_resp_valid(dbg_resp_valid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory: data for an address appears one cycle later.
  always @(posedge clk) begin
    if (preload) mem[4] <= 32'h8899AABB;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt     <= we_cnt + 1;
      last_wdata <= mem_wdata;
    end
    if (core_resp_valid) core_resp_cnt <= core_resp_cnt + 1;
    if (dbg_resp_valid)  dbg_resp_cnt  <= dbg_resp_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input bit is_dbg, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    bit got;
    if (is_dbg) begin
      dbg_req_valid = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      core_req_valid = 1'b1; core_we = we; core_funct3 = f3;
      core_addr = addr; core_wdata = wdata;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = is_dbg ? dbg_req_ready : core_req_ready;
    end
    check("accepted", {31'b0, got}, 32'd1);
    @(posedge clk);
    #1;
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;
    lat = 0; rdata = 'x; err = 'x; got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (is_dbg ? dbg_resp_valid : core_resp_valid) begin
        got   = 1'b1;
        lat   = i;
        rdata = is_dbg ? dbg_rdata : core_rdata;
        err   = core_err;
      end
    end
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          n_we;
    logic [31:0] mem_wdata;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, we0, cr0, dr0, g;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  seq;

    vecs[0]  = '{1'b0, F3_W,   32'h10, 32'h0,        3, 32'h8899AABB, 1'b0, 0, 32'h0};
    vecs[1]  = '{1'b0, F3_B,   32'h13, 32'h0,        3, 32'hFFFFFF88, 1'b0, 0, 32'h0};
    vecs[2]  = '{1'b0, F3_BU,  32'h13, 32'h0,        3, 32'h00000088, 1'b0, 0, 32'h0};
    vecs[3]  = '{1'b0, F3_H,   32'h12, 32'h0,        3, 32'hFFFF8899, 1'b0, 0, 32'h0};
    vecs[4]  = '{1'b0, F3_HU,  32'h10, 32'h0,        3, 32'h0000AABB, 1'b0, 0, 32'h0};
    vecs[5]  = '{1'b0, F3_B,   32'h10, 32'h0,        3, 32'hFFFFFFBB, 1'b0, 0, 32'h0};
    vecs[6]  = '{1'b1, F3_B,   32'h11, 32'h12345677, 4, 32'h0,        1'b0, 1, 32'h889977BB};
    vecs[7]  = '{1'b0, F3_W,   32'h10, 32'h0,        3, 32'h889977BB, 1'b0, 0, 32'h0};
    vecs[8]  = '{1'b0, F3_B,   32'h11, 32'h0,        3, 32'h00000077, 1'b0, 0, 32'h0};
    vecs[9]  = '{1'b0, F3_H,   32'h10, 32'h0,        3, 32'h000077BB, 1'b0, 0, 32'h0};
    vecs[10] = '{1'b0, F3_W,   32'h12, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0};
    vecs[11] = '{1'b1, F3_H,   32'h13, 32'h5555,     1, 32'h0,        1'b1, 0, 32'h0};
    vecs[12] = '{1'b0, 3'b011, 32'h10, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0};
    vecs[13] = '{1'b1, F3_BU,  32'h10, 32'h11,       1, 32'h0,        1'b1, 0, 32'h0};
    vecs[14] = '{1'b0, F3_HU,  32'h11, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0};
    vecs[15] = '{1'b0, F3_W,   32'h10, 32'h0,        3, 32'h889977BB, 1'b0, 0, 32'h0};

    // Reset state, with both requesters already valid.
    core_req_valid = 1'b1; core_we = 1'b0; core_funct3 = F3_W; core_addr = 32'h10;
    dbg_req_valid  = 1'b1; dbg_we  = 1'b0; dbg_addr = 32'h20;
    repeat (3) @(posedge clk);
    preload = 1'b0;
    @(negedge clk);
    check("rst_core_ready", {31'b0, core_req_ready}, 32'd0);
    check("rst_dbg_ready",  {31'b0, dbg_req_ready}, 32'd0);
    check("rst_mem_we",     {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr",   mem_addr, 32'h0);
    check("rst_core_resp",  {31'b0, core_resp_valid}, 32'd0);
    check("rst_dbg_resp",   {31'b0, dbg_resp_valid}, 32'd0);
    check("rst_core_rdata", core_rdata, 32'h0);

    // Round-robin with both ports valid from reset release.
    rst = 1'b0;
    #1;
    g = 0; seq = '0;
    for (int i = 0; i < 60 && g < 4; i++) begin
      if (core_req_ready || dbg_req_ready) begin
        check("single_grant", {31'b0, core_req_ready & dbg_req_ready}, 32'd0);
        seq[g] = dbg_req_ready;
        g++;
      end
      @(posedge clk);
      #1;
    end
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;
    check("grant_count", g, 32'd4);
    check("grant_order", {28'b0, seq}, 32'b1010);
    repeat (8) @(negedge clk);
    #1;
    check("arb_no_write", we_cnt, 32'd0);

    // Table-driven core accesses.
    for (int i = 0; i < NV; i++) begin
      we0 = we_cnt; dr0 = dbg_resp_cnt;
      do_req(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rdata, err);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
      check($sformatf("v%0d_writes", i), we_cnt - we0, vecs[i].n_we);
      check($sformatf("v%0d_dbg_quiet", i), dbg_resp_cnt - dr0, 32'd0);
      if (vecs[i].n_we != 0)
        check($sformatf("v%0d_mem_wdata", i), last_wdata, vecs[i].mem_wdata);
    end
    check("word_after_errors", mem[4], 32'h889977BB);

    // Debug port: word store, then load with low address bits ignored.
    we0 = we_cnt; cr0 = core_resp_cnt;
    do_req(1'b1, 1'b1, F3_W, 32'h20, 32'hDEADBEEF, lat, rdata, err);
    check("dbg_sw_latency", lat, 32'd2);
    check("dbg_sw_rdata", rdata, 32'h0);
    check("dbg_sw_writes", we_cnt - we0, 32'd1);
    check("dbg_sw_mem_wdata", last_wdata, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, F3_W, 32'h22, 32'h0, lat, rdata, err);
    check("dbg_lw_latency", lat, 32'd3);
    check("dbg_lw_rdata", rdata, 32'hDEADBEEF);
    check("dbg_core_quiet", core_resp_cnt - cr0, 32'd0);

    // Reset while a core SB sits in WAIT_RD.
    core_req_valid = 1'b1; core_we = 1'b1; core_funct3 = F3_B;
    core_addr = 32'h11; core_wdata = 32'h000000AA;
    g = 0;
    for (int i = 0; i < 20 && g == 0; i++) begin
      @(negedge clk);
      if (core_req_ready) g = 1;
    end
    check("sb_accepted", g, 32'd1);
    @(posedge clk);
    #1;
    core_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    we0 = we_cnt; cr0 = core_resp_cnt;
    core_req_valid = 1'b1; core_we = 1'b0; core_funct3 = F3_W; core_addr = 32'h10;
    @(negedge clk);
    check("rst_mid_ready_low", {31'b0, core_req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_ready_back", {31'b0, core_req_ready}, 32'd1);
    core_req_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("rst_mid_no_write", we_cnt - we0, 32'd0);
    check("rst_mid_no_resp", core_resp_cnt - cr0, 32'd0);
    check("rst_mid_word", mem[4], 32'h889977BB);
    do_req(1'b0, 1'b0, F3_W, 32'h10, 32'h0, lat, rdata, err);
    check("rst_mid_lw_latency", lat, 32'd3);
    check("rst_mid_lw_rdata", rdata, 32'h889977BB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
